// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
package div_pkg;

    // Operand/result width used when the parent does not override it.
    localparam int DIV_WIDTH_DEFAULT = 16;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Counter width able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : div_pkg

// File: rtl/div_datapath.sv
// Restoring-division datapath: partial remainder A, quotient/dividend shift
// register Q, divisor M, trial subtractor and iteration down-counter.
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             cnt_last_o,
    output logic             trial_neg_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   trial;

    // Shift {A,Q} left by one and form the trial subtraction A - {0,M}.
    always_comb begin
        a_shift     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_shift     = {q_q[WIDTH-2:0], 1'b0};
        trial       = a_shift - {1'b0, m_q};
        trial_neg_o = trial[WIDTH];
    end

    // Next-state selection for load, one iteration step, or hold.
    // A zero divisor loads the final result directly (Q all ones,
    // A = dividend) so the controller can skip the iteration entirely.
    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        if (load_i) begin
            m_d   = divisor_i;
            cnt_d = CW'(WIDTH);
            if (divisor_i == '0) begin
                a_d = {1'b0, dividend_i};
                q_d = '1;
            end else begin
                a_d = '0;
                q_d = dividend_i;
            end
        end else if (shift_i) begin
            cnt_d = cnt_q - CW'(1);
            if (commit_i) begin
                a_d = trial;
                q_d = q_shift | WIDTH'(1);
            end else begin
                a_d = a_shift;
                q_d = q_shift;
            end
        end
    end

    // Datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    // Status and results; cnt_last marks the step that takes the counter to 0.
    always_comb begin
        quo_o      = q_q;
        rem_o      = a_q[WIDTH-1:0];
        cnt_last_o = (cnt_q == CW'(1));
    end

endmodule : div_datapath

// File: rtl/restoring_divider.sv
// Restoring divider controller: accepts a start, runs WIDTH iterations on
// the datapath and pulses done for one cycle with results held afterwards.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | waiting for start; results of last op held
//   ST_CALC | one quotient bit per cycle, busy high, starts ignored
//   ST_DONE | done pulse for one cycle; a start here is accepted
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e state_q, state_d;
    logic       dbz_q, dbz_d;
    logic       load, shift, commit;
    logic       cnt_last, trial_neg;
    logic       div_zero;

    assign div_zero = (divisor == '0);

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .shift_i     (shift),
        .commit_i    (commit),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .quo_o       (quotient),
        .rem_o       (remainder),
        .cnt_last_o  (cnt_last),
        .trial_neg_o (trial_neg)
    );

    // Next state, datapath controls and the zero-divisor flag update.
    always_comb begin
        state_d = state_q;
        dbz_d   = dbz_q;
        load    = 1'b0;
        shift   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    dbz_d   = div_zero;
                    state_d = div_zero ? ST_DONE : ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                shift  = 1'b1;
                commit = ~trial_neg;
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs decoded straight from state so they clear with reset.
    always_comb begin
        busy        = (state_q == ST_CALC);
        done        = (state_q == ST_DONE);
        div_by_zero = dbz_q;
    end

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider with a result scoreboard.
module tb_restoring_divider;

    localparam int W     = 16;
    localparam int LIMIT = 100;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dbz;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: unsigned division with the zero-divisor convention.
    function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        if (dv == '0) begin
            e.quo = '1;
            e.rem = dd;
            e.dbz = 1'b1;
        end else begin
            e.quo = dd / dv;
            e.rem = dd % dv;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drive one start pulse across a rising edge; returns 1 time unit after it.
    task automatic pulse_start(input logic [W-1:0] dd, input logic [W-1:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom_range(0, 65535);
        divisor  = $urandom_range(0, 65535);
    endtask

    task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv);
        pulse_start(dd, dv);
        sb.push_back(model(dd, dv));
    endtask

    // Wait for done counting edges, then pop and compare the scoreboard entry.
    task automatic wait_done(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (done !== 1'b1 && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".done_seen"}, 32'(done), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".quotient"}, 32'(quotient), 32'(e.quo));
            chk({tag, ".remainder"}, 32'(remainder), 32'(e.rem));
            chk({tag, ".dbz"}, 32'(div_by_zero), 32'(e.dbz));
        end
    endtask

    // One idle cycle after done: pulse gone, results unchanged.
    task automatic check_hold(input string tag);
        logic [W-1:0] q0, r0;
        logic         z0;
        q0 = quotient;
        r0 = remainder;
        z0 = div_by_zero;
        @(posedge clk);
        #1;
        chk({tag, ".done_cleared"}, 32'(done), 32'd0);
        chk({tag, ".q_held"}, 32'(quotient), 32'(q0));
        chk({tag, ".r_held"}, 32'(remainder), 32'(r0));
        chk({tag, ".dbz_held"}, 32'(div_by_zero), 32'(z0));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state.
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.quotient", 32'(quotient), 32'd0);
        chk("rst.remainder", 32'(remainder), 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 100 / 7
        issue(16'd100, 16'd7);
        chk("t1.busy", 32'(busy), 32'd1);
        wait_done("t1", W);
        check_hold("t1");

        // 0xFFFF / 1, then 3 / 10
        issue(16'hFFFF, 16'h0001);
        wait_done("t2a", W);
        issue(16'd3, 16'd10);
        wait_done("t2b", W);
        check_hold("t2b");

        // 5 / 0: immediate done, busy never high
        issue(16'd5, 16'd0);
        chk("t3.busy", 32'(busy), 32'd0);
        wait_done("t3", 0);
        check_hold("t3");

        // 1000 / 9 with an ignored start in the middle
        issue(16'd1000, 16'd9);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        pulse_start(16'd50, 16'd5);
        chk("t4.busy_after_ignored", 32'(busy), 32'd1);
        wait_done("t4", W - 5);

        // Reset in the middle of CALC
        pulse_start(16'd200, 16'd3);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk("t5.busy_mid", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5.rst_busy", 32'(busy), 32'd0);
        chk("t5.rst_done", 32'(done), 32'd0);
        chk("t5.rst_quotient", 32'(quotient), 32'd0);
        chk("t5.rst_remainder", 32'(remainder), 32'd0);
        chk("t5.rst_dbz", 32'(div_by_zero), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t5.no_done_in_rst", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("t5.no_done_after_rst", 32'(done), 32'd0);
        end
        issue(16'd81, 16'd9);
        wait_done("t5", W);

        // Back-to-back: start accepted in the DONE cycle, old results held until then
        issue(16'd3, 16'd10);
        wait_done("t6a", W);
        @(negedge clk);
        dividend = 16'd250;
        divisor  = 16'd16;
        start    = 1'b1;
        chk("t6.done_at_accept", 32'(done), 32'd1);
        chk("t6.q_before_accept", 32'(quotient), 32'd0);
        chk("t6.r_before_accept", 32'(remainder), 32'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(16'd250, 16'd16));
        chk("t6.busy", 32'(busy), 32'd1);
        wait_done("t6b", W);
        // Back-to-back into a zero divisor straight from DONE
        issue(16'd7, 16'd0);
        wait_done("t6c", 0);
        check_hold("t6c");
        // And a random pair to finish
        issue(16'(16'hBEEF), 16'd123);
        wait_done("t7", W);

        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_restoring_divider
